// File: rtl/tcpc_regs_pkg.sv
// tcpc_regs_pkg
// Shared constants for the TCPC register responder:
//   - byte addresses of the fixed registers in the register map
//   - FSM state encoding of the bus handshake
//   - width of the ALERT / ALERT_MASK registers
package tcpc_regs_pkg;

  localparam int ALERT_W = 16;

  localparam logic [7:0] ADDR_VID_L        = 8'h00;
  localparam logic [7:0] ADDR_VID_H        = 8'h01;
  localparam logic [7:0] ADDR_PID_L        = 8'h02;
  localparam logic [7:0] ADDR_PID_H        = 8'h03;
  localparam logic [7:0] ADDR_ALERT_L      = 8'h10;
  localparam logic [7:0] ADDR_ALERT_H      = 8'h11;
  localparam logic [7:0] ADDR_ALERT_MASK_L = 8'h12;
  localparam logic [7:0] ADDR_ALERT_MASK_H = 8'h13;
  localparam logic [7:0] ADDR_GP_BASE      = 8'h14;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

endpackage

// File: rtl/tcpc_alert_reg.sv
// tcpc_alert_reg
// ALERT register with write-1-to-clear bytes, ALERT_MASK storage and the
// registered alert interrupt.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   alert_wr_en  - per-byte W1C strobes for ALERT (bit0 = low byte)
//   mask_wr_en   - per-byte write strobes for ALERT_MASK
//   wr_data      - byte written by the bus access
//   alert_set    - one-cycle hardware event pulses
//   alert        - current ALERT value
//   alert_mask   - current ALERT_MASK value
//   irq          - registered OR of (alert & alert_mask)
module tcpc_alert_reg
  import tcpc_regs_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         alert_wr_en,
  input  logic [1:0]         mask_wr_en,
  input  logic [7:0]         wr_data,
  input  logic [ALERT_W-1:0] alert_set,
  output logic [ALERT_W-1:0] alert,
  output logic [ALERT_W-1:0] alert_mask,
  output logic               irq
);

  logic [ALERT_W-1:0] clear_mask;

  // The clear is applied before the OR with alert_set, so a hardware event
  // on the same bit as a W1C write keeps the bit set.
  always_comb begin
    clear_mask = {({8{alert_wr_en[1]}} & wr_data), ({8{alert_wr_en[0]}} & wr_data)};
  end

  // irq is computed from the pre-edge register values, so it trails any
  // ALERT or mask change by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      alert      <= '0;
      alert_mask <= '1;
      irq        <= 1'b0;
    end else begin
      alert <= (alert & ~clear_mask) | alert_set;
      if (mask_wr_en[0]) alert_mask[7:0]  <= wr_data;
      if (mask_wr_en[1]) alert_mask[15:8] <= wr_data;
      irq <= |(alert & alert_mask);
    end
  end

endmodule

// File: rtl/tcpc_regs_responder.sv
// tcpc_regs_responder
// Register-bank responder on the shared register-access bus. Serves one
// request at a time with a registered four-phase REQUEST/ACK handshake and
// holds the ID bytes, ALERT, ALERT_MASK and general-purpose byte storage.
// Ports:
//   CLK, RESET      - clock, synchronous active-high reset
//   REQUEST         - access request, held until ACK is seen
//   RNW             - 1 = read, 0 = write
//   ADDR, WR_DATA   - byte address and write data (captured in IDLE)
//   ACK             - access complete, held until REQUEST falls
//   RD_DATA         - read data, valid while ACK=1, 0x00 after a write
//   ALERT_SET       - hardware event pulses setting ALERT bits
//   ALERT_STATUS    - current ALERT register
//   INT             - registered alert interrupt
module tcpc_regs_responder
  import tcpc_regs_pkg::*;
#(
  parameter int          DEPTH      = 128,
  parameter logic [15:0] VENDOR_ID  = 16'h0000,
  parameter logic [15:0] PRODUCT_ID = 16'h0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQUEST,
  input  logic        RNW,
  input  logic [7:0]  ADDR,
  input  logic [7:0]  WR_DATA,
  output logic        ACK,
  output logic [7:0]  RD_DATA,
  input  logic [15:0] ALERT_SET,
  output logic [15:0] ALERT_STATUS,
  output logic        INT
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]       state;
  logic [7:0]       cmd_addr;
  logic             cmd_rnw;
  logic [7:0]       cmd_wdata;
  logic [7:0]       gp_mem [DEPTH];
  logic [IDX_W-1:0] gp_idx;
  logic             in_gp;
  logic             do_write;
  logic [1:0]       alert_wr_en;
  logic [1:0]       mask_wr_en;
  logic [15:0]      alert_mask;
  logic [7:0]       rd_mux;

  // All decoding works from the captured command, never from the live bus.
  always_comb begin
    in_gp       = (cmd_addr >= ADDR_GP_BASE) && (int'(cmd_addr) < DEPTH);
    gp_idx      = cmd_addr[IDX_W-1:0];
    do_write    = (state == ST_ACCESS) && !cmd_rnw;
    alert_wr_en = {do_write && (cmd_addr == ADDR_ALERT_H),
                   do_write && (cmd_addr == ADDR_ALERT_L)};
    mask_wr_en  = {do_write && (cmd_addr == ADDR_ALERT_MASK_H),
                   do_write && (cmd_addr == ADDR_ALERT_MASK_L)};
  end

  // Reserved ID space (0x04-0x0F) and addresses past DEPTH fall to 0x00.
  always_comb begin
    rd_mux = 8'h00;
    case (cmd_addr)
      ADDR_VID_L:        rd_mux = VENDOR_ID[7:0];
      ADDR_VID_H:        rd_mux = VENDOR_ID[15:8];
      ADDR_PID_L:        rd_mux = PRODUCT_ID[7:0];
      ADDR_PID_H:        rd_mux = PRODUCT_ID[15:8];
      ADDR_ALERT_L:      rd_mux = ALERT_STATUS[7:0];
      ADDR_ALERT_H:      rd_mux = ALERT_STATUS[15:8];
      ADDR_ALERT_MASK_L: rd_mux = alert_mask[7:0];
      ADDR_ALERT_MASK_H: rd_mux = alert_mask[15:8];
      default:           if (in_gp) rd_mux = gp_mem[gp_idx];
    endcase
  end

  // Handshake: capture in IDLE, access in ACCESS, then wait in DONE for
  // REQUEST to drop so a held request produces only one access.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_IDLE;
      cmd_addr  <= 8'h00;
      cmd_rnw   <= 1'b0;
      cmd_wdata <= 8'h00;
      ACK       <= 1'b0;
      RD_DATA   <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (REQUEST) begin
            cmd_addr  <= ADDR;
            cmd_rnw   <= RNW;
            cmd_wdata <= WR_DATA;
            state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          RD_DATA <= cmd_rnw ? rd_mux : 8'h00;
          ACK     <= 1'b1;
          state   <= ST_DONE;
        end
        ST_DONE: begin
          if (!REQUEST) begin
            ACK   <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // General-purpose storage; entries below ADDR_GP_BASE are never addressed.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) gp_mem[i] <= 8'h00;
    end else if (do_write && in_gp) begin
      gp_mem[gp_idx] <= cmd_wdata;
    end
  end

  tcpc_alert_reg u_alert (
    .clk         (CLK),
    .reset       (RESET),
    .alert_wr_en (alert_wr_en),
    .mask_wr_en  (mask_wr_en),
    .wr_data     (cmd_wdata),
    .alert_set   (ALERT_SET),
    .alert       (ALERT_STATUS),
    .alert_mask  (alert_mask),
    .irq         (INT)
  );

endmodule

// File: tb/tb_tcpc_regs_responder.sv
// tb_tcpc_regs_responder
// Directed and randomized bus transactions against a register-map model
// kept as plain arrays and integers.
module tb_tcpc_regs_responder;

  localparam int          DEPTH = 128;
  localparam logic [15:0] VID   = 16'h1234;
  localparam logic [15:0] PID   = 16'hBEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        request;
  logic        rnw;
  logic [7:0]  addr;
  logic [7:0]  wr_data;
  logic        ack;
  logic [7:0]  rd_data;
  logic [15:0] alert_set;
  logic [15:0] alert_status;
  logic        int_out;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state.
  logic [7:0]  m_mem [256];
  logic [15:0] m_alert;
  logic [15:0] m_mask;

  tcpc_regs_responder #(
    .DEPTH      (DEPTH),
    .VENDOR_ID  (VID),
    .PRODUCT_ID (PID)
  ) dut (
    .CLK          (clk),
    .RESET        (reset),
    .REQUEST      (request),
    .RNW          (rnw),
    .ADDR         (addr),
    .WR_DATA      (wr_data),
    .ACK          (ack),
    .RD_DATA      (rd_data),
    .ALERT_SET    (alert_set),
    .ALERT_STATUS (alert_status),
    .INT          (int_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_int();
    return |(m_alert & m_mask);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
    m_alert = 16'h0000;
    m_mask  = 16'hFFFF;
  endtask

  // Register map as seen by a bus read.
  function automatic logic [7:0] model_read(input logic [7:0] a);
    if (a == 8'h00) return VID[7:0];
    if (a == 8'h01) return VID[15:8];
    if (a == 8'h02) return PID[7:0];
    if (a == 8'h03) return PID[15:8];
    if (a < 8'h10)  return 8'h00;
    if (a == 8'h10) return m_alert[7:0];
    if (a == 8'h11) return m_alert[15:8];
    if (a == 8'h12) return m_mask[7:0];
    if (a == 8'h13) return m_mask[15:8];
    if (int'(a) < DEPTH) return m_mem[a];
    return 8'h00;
  endfunction

  // Effect of the access cycle on the model, including any event pulse
  // landing in the same cycle.
  task automatic model_access(input logic r, input logic [7:0] a, input logic [7:0] d,
                              input logic [15:0] set);
    logic [15:0] clr;
    clr = 16'h0000;
    if (!r) begin
      if (a == 8'h10) clr[7:0]  = d;
      if (a == 8'h11) clr[15:8] = d;
      if (a == 8'h12) m_mask[7:0]  = d;
      if (a == 8'h13) m_mask[15:8] = d;
      if (a >= 8'h14 && int'(a) < DEPTH) m_mem[a] = d;
    end
    m_alert = (m_alert & ~clr) | set;
  endtask

  // One full four-phase transaction. 'set' is pulsed during the access
  // cycle; 'hold' extra cycles keep REQUEST high while the bus inputs are
  // scrambled, which the responder must ignore.
  task automatic bus_access(input logic r, input logic [7:0] a, input logic [7:0] d,
                            input logic [15:0] set, input int hold);
    logic [7:0] exp_rd;
    @(negedge clk);
    request = 1'b1; rnw = r; addr = a; wr_data = d;
    @(posedge clk); #1;
    check("ack_early", {15'd0, ack}, 16'd0);
    alert_set = set;
    rnw = 1'($urandom); addr = 8'($urandom); wr_data = 8'($urandom);
    @(posedge clk); #1;
    alert_set = 16'h0000;
    exp_rd = r ? model_read(a) : 8'h00;
    model_access(r, a, d, set);
    check("ack_rise", {15'd0, ack}, 16'd1);
    check($sformatf("rd_data@%02h", a), {8'd0, rd_data}, {8'd0, exp_rd});
    check("alert_status", alert_status, m_alert);
    for (int i = 0; i < hold; i++) begin
      rnw = 1'($urandom); addr = 8'($urandom); wr_data = 8'($urandom);
      @(posedge clk); #1;
      check("ack_hold", {15'd0, ack}, 16'd1);
      check("rd_hold", {8'd0, rd_data}, {8'd0, exp_rd});
    end
    @(negedge clk);
    request = 1'b0;
    @(posedge clk); #1;
    check("ack_fall", {15'd0, ack}, 16'd0);
    check("rd_keep", {8'd0, rd_data}, {8'd0, exp_rd});
    check("int", {15'd0, int_out}, {15'd0, exp_int()});
  endtask

  task automatic read_expect(input logic [7:0] a, input logic [7:0] exp);
    check($sformatf("model_rd@%02h", a), {8'd0, model_read(a)}, {8'd0, exp});
    bus_access(1'b1, a, 8'h00, 16'h0000, 0);
  endtask

  // Hardware event pulse while the bus is idle.
  task automatic alert_pulse(input logic [15:0] set);
    @(negedge clk);
    alert_set = set;
    @(posedge clk); #1;
    alert_set = 16'h0000;
    m_alert = m_alert | set;
    check("alert_after_set", alert_status, m_alert);
    @(posedge clk); #1;
    check("int_after_set", {15'd0, int_out}, {15'd0, exp_int()});
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("rst_ack", {15'd0, ack}, 16'd0);
    check("rst_rd", {8'd0, rd_data}, 16'd0);
    check("rst_int", {15'd0, int_out}, 16'd0);
    check("rst_alert", alert_status, 16'h0000);
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0]  ra;
    logic [15:0] rs;

    reset = 1'b1; request = 1'b0; rnw = 1'b0; addr = 8'h00; wr_data = 8'h00;
    alert_set = 16'h0000;
    model_reset();
    apply_reset();

    // ID bytes.
    read_expect(8'h00, 8'h34);
    read_expect(8'h01, 8'h12);
    read_expect(8'h02, 8'hEF);
    read_expect(8'h03, 8'hBE);

    // General storage and a dropped write to reserved space.
    bus_access(1'b0, 8'h20, 8'h5A, 16'h0000, 0);
    read_expect(8'h20, 8'h5A);
    bus_access(1'b0, 8'h05, 8'h77, 16'h0000, 0);
    read_expect(8'h05, 8'h00);

    // Alert set, interrupt lag, W1C.
    alert_pulse(16'h0005);
    check("int_on", {15'd0, int_out}, 16'd1);
    bus_access(1'b0, 8'h10, 8'h01, 16'h0000, 0);
    check("alert_w1c", alert_status, 16'h0004);

    // Set beats clear on the same bit in the same cycle.
    bus_access(1'b0, 8'h10, 8'h04, 16'h0004, 0);
    check("set_wins", alert_status, 16'h0004);
    bus_access(1'b0, 8'h12, 8'h00, 16'h0000, 0);
    bus_access(1'b0, 8'h13, 8'h00, 16'h0000, 0);
    check("int_masked", {15'd0, int_out}, 16'd0);
    read_expect(8'h12, 8'h00);

    // Long-held request with inputs changing after capture.
    bus_access(1'b0, 8'h30, 8'h11, 16'h0000, 10);
    @(posedge clk); #1;
    check("no_second_ack", {15'd0, ack}, 16'd0);
    read_expect(8'h30, 8'h11);
    read_expect(8'hF0, 8'h00);
    bus_access(1'b0, 8'hF0, 8'hAA, 16'h0000, 0);
    read_expect(8'hF0, 8'h00);
    read_expect(8'h7F, 8'h00);
    bus_access(1'b0, 8'h7F, 8'hC3, 16'h0000, 1);
    read_expect(8'h7F, 8'hC3);

    // Reset during the access cycle of a write.
    @(negedge clk);
    request = 1'b1; rnw = 1'b0; addr = 8'h20; wr_data = 8'h99;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    request = 1'b0;
    model_reset();
    check("rst_mid_ack", {15'd0, ack}, 16'd0);
    check("rst_mid_rd", {8'd0, rd_data}, 16'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_mid_ack2", {15'd0, ack}, 16'd0);
    read_expect(8'h20, 8'h00);
    read_expect(8'h12, 8'hFF);
    read_expect(8'h13, 8'hFF);

    // Randomized traffic concentrated around the alert registers.
    for (int n = 0; n < 80; n++) begin
      ra = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(16, 23)) : 8'($urandom);
      rs = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'h0000;
      bus_access(1'($urandom), ra, 8'($urandom), rs, $urandom_range(0, 2));
      if ($urandom_range(0, 4) == 0) alert_pulse(16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
